// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// Existing combinational 1-bit full-adder cell, reused by the serial adder.
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell processes the operands LSB
// first, one bit per clock, with a start/busy/done handshake around it.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit so WIDTH=1 and powers of two never wrap on the
    // final increment.
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;

    logic             s_s;
    logic             c_s;
    logic [WIDTH-1:0] sum_sh_next_s;

    adder u_adder (
        .a   (a_sh_r[0]),
        .b   (b_sh_r[0]),
        .cin (carry_r),
        .s   (s_s),
        .c   (c_s)
    );

    // Next partial-sum register: shift right and insert the new bit at the
    // MSB; written this way so it also holds for WIDTH=1.
    always_comb begin
        sum_sh_next_s             = sum_sh_r >> 1'b1;
        sum_sh_next_s[WIDTH-1]    = s_s;
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r   <= a;
                        b_sh_r   <= b;
                        carry_r  <= cin;
                        sum_sh_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh_r   <= a_sh_r >> 1'b1;
                    b_sh_r   <= b_sh_r >> 1'b1;
                    sum_sh_r <= sum_sh_next_s;
                    carry_r  <= c_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        sum_r   <= sum_sh_next_s;
                        cout_r  <= c_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, multi-cycle corner
// sequences, random operands at WIDTH=8 and an exhaustive sweep at WIDTH=4.
module tb_serial_adder;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start, cin, busy, done, cout;
    logic [W-1:0] a, b, sum;

    logic          start4, cin4, busy4, done4, cout4;
    logic [W4-1:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands with start for exactly one accepting edge.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(posedge clk); #1;
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count negedges after the accepting edge until done (bounded).
    task automatic wait_done(output int k, output int nbusy);
        k = 0;
        nbusy = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (busy) nbusy++;
            if (done) break;
        end
    endtask

    task automatic op4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        int k;
        logic [4:0] exp;
        @(posedge clk); #1;
        a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (done4) break;
        end
        exp = 5'(va) + 5'(vb) + 5'(vc);
        check("w4_latency", k, W4 + 1);
        check("w4_result", {cout4, sum4}, exp);
    endtask

    initial begin
        int k, nb, m, pulses, off;
        logic [7:0] cap_sum;
        logic       cap_cout;
        logic [8:0] exp9;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] idx;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_done", done, 1'b0);

        // Vector table: result, latency, busy length and single done pulse.
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(k, nb);
            check("vec_latency", k, W + 1);
            check("vec_busy_cycles", nb, W);
            check("vec_sum", sum, vecs[i].sum);
            check("vec_cout", cout, vecs[i].cout);
            @(negedge clk);
            check("vec_done_one_cycle", done, 1'b0);
            check("vec_sum_hold", sum, vecs[i].sum);
        end

        // start re-asserted during SHIFT is ignored.
        launch(8'h03, 8'h04, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h55; b = 8'hAA; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        pulses = 0; cap_sum = 8'h00; cap_cout = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                cap_sum = sum;
                cap_cout = cout;
            end
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_sum", cap_sum, 8'h07);
        check("ignore_cout", cap_cout, 1'b0);

        // Back-to-back: start held through DONE with new operands.
        @(posedge clk); #1;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80;
        wait_done(k, nb);
        check("b2b_first_latency", k, W + 1);
        check("b2b_first_sum", sum, 8'h03);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(m, nb);
        check("b2b_gap", m, W + 1);
        check("b2b_sum", sum, 8'h00);
        check("b2b_cout", cout, 1'b1);

        // Asynchronous reset mid-SHIFT at cnt=3.
        launch(8'hFF, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_sum", sum, 8'h00);
        check("async_rst_cout", cout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("post_rst_quiet", pulses, 0);
        launch(8'h12, 8'h34, 1'b1);
        wait_done(k, nb);
        check("post_rst_latency", k, W + 1);
        check("post_rst_sum", sum, 8'h47);
        check("post_rst_cout", cout, 1'b0);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            launch(ra, rb, rc);
            wait_done(k, nb);
            check("rand_latency", k, W + 1);
            check("rand_result", {cout, sum}, exp9);
        end

        // Exhaustive WIDTH=4 sweep in a randomly rotated order.
        off = $urandom_range(0, 511);
        for (int i = 0; i < 512; i++) begin
            idx = 9'((i + off) % 512);
            op4(idx[3:0], idx[7:4], idx[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
